// File: rtl/uart_rx_deframer.sv
// UART byte-to-frame assembler: sync hunt, header/message shift-in,
// valid/ready frame hand-off and inter-byte timeout abort.
module uart_rx_deframer #(
    parameter int unsigned MESSAGE_SIZE   = 512,
    parameter int unsigned HEADER_SIZE    = 32,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 12000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    ll_valid_in,
    input  logic [7:0]              ll_byte_in,
    output logic                    ll_ready_out,
    output logic [HEADER_SIZE-1:0]  header_out,
    output logic [MESSAGE_SIZE-1:0] message_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    frame_error_out,
    output logic [7:0]              drop_count_out
);

    localparam int unsigned HDR_BYTES = HEADER_SIZE / 8;
    localparam int unsigned MSG_BYTES = MESSAGE_SIZE / 8;
    localparam int unsigned MAX_BYTES =
        (HDR_BYTES > MSG_BYTES) ? HDR_BYTES : MSG_BYTES;
    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        HUNT,
        HEADER,
        BODY,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic accept;
    logic is_sync;
    logic last_hdr;
    logic last_msg;
    logic in_frame;
    logic expire;

    assign accept   = ll_valid_in && ll_ready_out;
    assign is_sync  = (ll_byte_in == SYNC_BYTE);
    assign last_hdr = (byte_cnt == CNT_W'(HDR_BYTES - 1));
    assign last_msg = (byte_cnt == CNT_W'(MSG_BYTES - 1));
    assign in_frame = (state == HEADER) || (state == BODY);

    // Expiry fires on the edge where the idle count would reach
    // TIMEOUT_CYCLES-1; an accept on that edge takes priority.
    assign expire = in_frame && !accept &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HUNT: begin
                if (accept && is_sync) begin
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                if (accept && last_hdr) begin
                    state_nxt = BODY;
                end else if (expire) begin
                    state_nxt = HUNT;
                end
            end
            BODY: begin
                if (accept && last_msg) begin
                    state_nxt = HOLD;
                end else if (expire) begin
                    state_nxt = HUNT;
                end
            end
            HOLD: begin
                if (valid_out && ready_in) begin
                    state_nxt = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ll_ready_out    <= 1'b0;
            valid_out       <= 1'b0;
            frame_error_out <= 1'b0;
            header_out      <= '0;
            message_out     <= '0;
            drop_count_out  <= 8'd0;
            byte_cnt        <= '0;
            to_cnt          <= '0;
        end else begin
            ll_ready_out    <= (state_nxt != HOLD);
            valid_out       <= (state_nxt == HOLD);
            frame_error_out <= expire;

            if (expire && (drop_count_out != 8'hFF)) begin
                drop_count_out <= drop_count_out + 8'd1;
            end

            if (!in_frame || accept || expire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (state == HUNT) begin
                byte_cnt <= '0;
            end else if (accept && (state == HEADER)) begin
                header_out <= HEADER_SIZE'({header_out, ll_byte_in});
                byte_cnt   <= last_hdr ? '0 : byte_cnt + CNT_W'(1);
            end else if (accept && (state == BODY)) begin
                message_out <= MESSAGE_SIZE'({message_out, ll_byte_in});
                byte_cnt    <= last_msg ? '0 : byte_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Byte-to-frame assembler between the byte-level UART receiver and the controller's rx message outputs.
- Hunts for a sync byte, then shifts in a fixed-size header and message, MSB-first.
- Presents the assembled frame with a valid/ready handshake.
- Aborts partial frames on an inter-byte timeout and reports errors.

Parameters:
- MESSAGE_SIZE, 512, message payload width in bits; must be a multiple of 8 and at least 8.
- HEADER_SIZE, 32, header width in bits; must be a multiple of 8 and at least 8.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 12000, maximum clk_in cycles allowed between accepted bytes inside a frame; must be at least 2.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- ll_valid_in  input  1  byte available from the UART receiver.
- ll_byte_in  input  8  received byte.
- ll_ready_out  output  1  deframer accepts a byte this cycle.
- header_out  output  HEADER_SIZE  assembled header; first received header byte in the MSBs.
- message_out  output  MESSAGE_SIZE  assembled message; first received message byte in the MSBs.
- valid_out  output  1  frame available.
- ready_in  input  1  downstream consumes the frame.
- frame_error_out  output  1  one-cycle pulse on a timeout abort.
- drop_count_out  output  8  saturating count of aborted frames.

Behaviour:
- Derived constants: HDR_BYTES = HEADER_SIZE/8, MSG_BYTES = MESSAGE_SIZE/8.
- Byte counter width: clog2 of max(HDR_BYTES, MSG_BYTES)+1.
- A byte is accepted on a rising edge where ll_valid_in && ll_ready_out.
- Reset (rst_in low, asynchronous):
  - state = HUNT;
  - ll_ready_out, valid_out, frame_error_out = 0;
  - header_out, message_out = 0;
  - drop_count_out = 0;
  - byte and timeout counters = 0.
- ll_ready_out is registered. It rises on the first edge after reset release and is 1 in HUNT, HEADER and BODY.
- HUNT:
  - An accepted byte equal to SYNC_BYTE -> HEADER, byte counter cleared.
  - Any other accepted byte is discarded silently: no error, no count.
  - The timeout counter is inactive.
- HEADER:
  - Each accepted byte: header_out <= {header_out[HEADER_SIZE-9:0], byte}; counter increments.
  - On the HDR_BYTES-th byte -> BODY, counter cleared.
  - A byte equal to SYNC_BYTE is data here, not a restart.
- BODY:
  - Same shifting into message_out.
  - On the MSG_BYTES-th byte -> HOLD.
  - On that same edge ll_ready_out <= 0 and valid_out <= 1, so valid_out is high the cycle after the last byte handshake.
- HOLD:
  - ll_ready_out = 0; no bytes accepted; header_out and message_out held stable.
  - On an edge with valid_out && ready_in: valid_out <= 0, ll_ready_out <= 1, state -> HUNT. Frame-to-next-accept latency is 1 cycle.
  - ready_in is ignored outside HOLD.
- Timeout (HEADER and BODY only):
  - The counter clears on every accepted byte and on entry to HEADER.
  - It increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no byte accepted that cycle: frame_error_out pulses for exactly 1 cycle, drop_count_out increments (saturating at 255), header_out and message_out keep their partial contents, state -> HUNT.
  - An accept and an expiry on the same cycle: the accept wins and no error is raised.
- header_out and message_out are only meaningful while valid_out = 1. Partial shifting in later frames is visible on them.
- Reset mid-frame or in HOLD returns everything to the reset values; a pending frame is lost and not counted.
- No parity or checksum checks are performed; a header length field is not interpreted.

Test Plan:
- Bench config: MESSAGE_SIZE=16, HEADER_SIZE=8, TIMEOUT_CYCLES=50.
- Clean frame: bytes A5,3C,12,34 back-to-back, ready_in=1 -> valid_out high the cycle after byte 34; header_out=8'h3C, message_out=16'h1234; ll_ready_out low for exactly 1 cycle; frame_error_out never pulses.
- Hunt noise: bytes 00,FF,5A, then A5,01,AB,CD -> junk ignored; frame header=01, message=ABCD; drop_count_out stays 0.
- Backpressure: complete a frame with ready_in=0 for 20 cycles while ll_valid_in=1 with byte 77 -> valid_out and data held; ll_ready_out=0 throughout; after ready_in=1, valid_out drops next cycle and ll_ready_out=1.
- Timeout: A5,10, then 60 idle cycles -> frame_error_out pulses once, 49 cycles after the 10 byte; drop_count_out=1; a following full frame A5,22,33,44 is delivered correctly.
- Boundary: byte accepted exactly on the expiry cycle -> no error, frame continues. Separately, 300 timed-out frames -> drop_count_out saturates at 255.
- Reset mid-body: assert rst_in after A5,3C,12 -> all outputs 0 immediately; after release, ll_ready_out=1 next edge; a new frame is assembled correctly.
